// File: rtl/candy_sram_ctrl.sv
// candy_sram_ctrl: arbitrates an instruction-fetch port and a load/store port
// onto a single asynchronous 32-bit SRAM. Each access holds the strobes for
// WaitCycles cycles, then spends one DONE cycle pulsing the granted ack.
module candy_sram_ctrl #(
  parameter int SramAddrW  = 20,
  parameter int WaitCycles = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req_i,
  input  logic [31:0]          if_addr_i,
  output logic [31:0]          if_data_o,
  output logic                 if_ack_o,
  input  logic                 mem_req_i,
  input  logic                 mem_we_i,
  input  logic [31:0]          mem_addr_i,
  input  logic [3:0]           mem_sel_i,
  input  logic [31:0]          mem_wdata_i,
  output logic [31:0]          mem_rdata_o,
  output logic                 mem_ack_o,
  output logic                 stall_o,
  output logic [SramAddrW-1:0] sram_addr_o,
  inout  wire  [31:0]          sram_data_io,
  output logic [3:0]           sram_be_o,
  output logic                 chip_enable_o,
  output logic                 write_enable_o,
  output logic                 read_enable_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WaitCycles);

  state_t               r_state, w_state_next;
  logic [3:0]           r_cnt, w_cnt_next;
  logic                 r_gnt_mem, w_gnt_mem_next;
  logic                 r_we, w_we_next;
  logic [SramAddrW-1:0] r_word_addr, w_word_addr_next;
  logic [31:0]          r_wdata, w_wdata_next;
  logic                 r_ce, w_ce_next;
  logic                 r_re, w_re_next;
  logic                 r_wr, w_wr_next;
  logic [3:0]           r_be, w_be_next;
  logic                 r_drive, w_drive_next;
  logic                 r_if_ack, w_if_ack_next;
  logic                 r_mem_ack, w_mem_ack_next;
  logic [31:0]          r_if_data, w_if_data_next;
  logic [31:0]          r_mem_rdata, w_mem_rdata_next;

  // Byte-offset bits and bits above the SRAM word range are deliberately ignored.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{if_addr_i[31:SramAddrW+2], if_addr_i[1:0],
                                mem_addr_i[31:SramAddrW+2], mem_addr_i[1:0]};

  // Next-state and next-output logic; strobes are computed one cycle ahead so
  // that they leave the block straight from flops.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_gnt_mem_next   = r_gnt_mem;
    w_we_next        = r_we;
    w_word_addr_next = r_word_addr;
    w_wdata_next     = r_wdata;
    w_ce_next        = r_ce;
    w_re_next        = r_re;
    w_wr_next        = r_wr;
    w_be_next        = r_be;
    w_drive_next     = r_drive;
    w_if_ack_next    = 1'b0;
    w_mem_ack_next   = 1'b0;
    w_if_data_next   = r_if_data;
    w_mem_rdata_next = r_mem_rdata;
    case (r_state)
      ST_IDLE: begin
        if (mem_req_i || if_req_i) begin
          w_state_next = ST_ACCESS;
          w_cnt_next   = WAIT_LOAD;
          w_ce_next    = 1'b1;
          if (mem_req_i) begin
            // Load/store port wins any tie.
            w_gnt_mem_next   = 1'b1;
            w_we_next        = mem_we_i;
            w_word_addr_next = mem_addr_i[SramAddrW+1:2];
            w_wdata_next     = mem_wdata_i;
            w_re_next        = ~mem_we_i;
            w_wr_next        = mem_we_i;
            w_be_next        = mem_we_i ? mem_sel_i : 4'hF;
            w_drive_next     = mem_we_i;
          end else begin
            w_gnt_mem_next   = 1'b0;
            w_we_next        = 1'b0;
            w_word_addr_next = if_addr_i[SramAddrW+1:2];
            w_re_next        = 1'b1;
            w_wr_next        = 1'b0;
            w_be_next        = 4'hF;
            w_drive_next     = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        if (r_cnt <= 4'd1) begin
          // Last strobe cycle: sample the bus and release everything.
          w_state_next = ST_DONE;
          w_cnt_next   = 4'd0;
          w_ce_next    = 1'b0;
          w_re_next    = 1'b0;
          w_wr_next    = 1'b0;
          w_be_next    = 4'h0;
          w_drive_next = 1'b0;
          if (r_gnt_mem) begin
            w_mem_ack_next = 1'b1;
            if (!r_we) begin
              w_mem_rdata_next = sram_data_io;
            end
          end else begin
            w_if_ack_next  = 1'b1;
            w_if_data_next = sram_data_io;
          end
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset that aborts any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_gnt_mem   <= 1'b0;
      r_we        <= 1'b0;
      r_word_addr <= '0;
      r_wdata     <= 32'd0;
      r_ce        <= 1'b0;
      r_re        <= 1'b0;
      r_wr        <= 1'b0;
      r_be        <= 4'h0;
      r_drive     <= 1'b0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_if_data   <= 32'd0;
      r_mem_rdata <= 32'd0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_gnt_mem   <= w_gnt_mem_next;
      r_we        <= w_we_next;
      r_word_addr <= w_word_addr_next;
      r_wdata     <= w_wdata_next;
      r_ce        <= w_ce_next;
      r_re        <= w_re_next;
      r_wr        <= w_wr_next;
      r_be        <= w_be_next;
      r_drive     <= w_drive_next;
      r_if_ack    <= w_if_ack_next;
      r_mem_ack   <= w_mem_ack_next;
      r_if_data   <= w_if_data_next;
      r_mem_rdata <= w_mem_rdata_next;
    end
  end

  assign sram_data_io   = r_drive ? r_wdata : 32'bz;
  assign sram_addr_o    = r_word_addr;
  assign sram_be_o      = r_be;
  assign chip_enable_o  = r_ce;
  assign read_enable_o  = r_re;
  assign write_enable_o = r_wr;
  assign if_ack_o       = r_if_ack;
  assign mem_ack_o      = r_mem_ack;
  assign if_data_o      = r_if_data;
  assign mem_rdata_o    = r_mem_rdata;
  assign stall_o        = (if_req_i & ~r_if_ack) | (mem_req_i & ~r_mem_ack);

endmodule
